// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Four-digit multiplexed scan controller for an active-low seven-segment
// display. Display data lives in shadow registers that are reloaded from the
// live inputs only at a frame boundary, under an upd_req/upd_ack handshake.
// Each digit slot opens with a dead-time blank and may be PWM-dimmed.
//
// Build option: define SEG_PWM_EN to build the brightness PWM. Without it, a
// digit that is enabled is lit for the whole ON phase and bright is ignored.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   seg0..seg3        active-low segment patterns (seg0 -> an[0], rightmost)
//   dp_in             active-high decimal point request per digit
//   dig_en            active-high digit enable per digit
//   bright            brightness code 0..15
//   upd_req           request to load the live inputs into the shadows
//   upd_ack           one-cycle pulse, shadows loaded (coincides with frame_start)
//   frame_start       one-cycle pulse at the first cycle of slot 0
//   an, sseg, dp      active-low display outputs, all registered
//
// Slot FSM
//   state    | meaning
//   ST_BLANK | dead-time at the start of a slot, everything off
//   ST_ON    | remainder of the slot, current digit may be lit
module seg_scan_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] dp_in,
  input  logic [3:0] dig_en,
  input  logic [3:0] bright,
  input  logic       upd_req,
  output logic       upd_ack,
  output logic       frame_start,
  output logic [3:0] an,
  output logic [6:0] sseg,
  output logic       dp
);

  localparam int SLOT_W = $clog2(TICK_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]        digit_q, digit_d;

  logic [3:0][6:0]   seg_sh_q, seg_sh_d;
  logic [3:0]        dp_sh_q, dp_sh_d;
  logic [3:0]        dig_en_sh_q, dig_en_sh_d;

  logic              ack_pend_q, ack_pend_d;
  logic              upd_ack_q, upd_ack_d;
  logic              frame_start_q, frame_start_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        sseg_q, sseg_d;
  logic              dp_q, dp_d;

  logic              frame_end;
  logic              load_sh;
  logic              dig_on;

`ifdef SEG_PWM_EN
  logic [3:0]        pwm_cnt_q, pwm_cnt_d;
  logic [3:0]        bright_sh_q, bright_sh_d;
`else
  logic [3:0]        bright_unused;
  assign bright_unused = bright;
`endif

  // Slot counter and digit index
  always_comb begin
    slot_cnt_d = slot_cnt_q + SLOT_W'(1);
    digit_d    = digit_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end
  end

  assign frame_end = (digit_q == 2'd3) && (slot_cnt_q == SLOT_LAST);

  // Slot FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (slot_cnt_q == BLANK_LAST) state_d = ST_ON;
      ST_ON:    if (slot_cnt_q == SLOT_LAST)  state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

`ifdef SEG_PWM_EN
  // PWM phase restarts at the first ON cycle of every slot.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    if (state_q == ST_BLANK && state_d == ST_ON) pwm_cnt_d = 4'd0;
  end
`endif

  // Shadow load on the frame-end cycle only; ack follows one cycle later so
  // that it lines up with the registered frame_start pulse.
  assign load_sh = frame_end && upd_req;

  always_comb begin
    seg_sh_d    = seg_sh_q;
    dp_sh_d     = dp_sh_q;
    dig_en_sh_d = dig_en_sh_q;
`ifdef SEG_PWM_EN
    bright_sh_d = bright_sh_q;
`endif
    if (load_sh) begin
      seg_sh_d    = {seg3, seg2, seg1, seg0};
      dp_sh_d     = dp_in;
      dig_en_sh_d = dig_en;
`ifdef SEG_PWM_EN
      bright_sh_d = bright;
`endif
    end
  end

  // Output decode of the current counter/state, registered below
  always_comb begin
`ifdef SEG_PWM_EN
    dig_on = (state_q == ST_ON) && dig_en_sh_q[digit_q] && (pwm_cnt_q <= bright_sh_q);
`else
    dig_on = (state_q == ST_ON) && dig_en_sh_q[digit_q];
`endif
    an_d          = 4'hF;
    sseg_d        = 7'h7F;
    dp_d          = 1'b1;
    ack_pend_d    = load_sh;
    upd_ack_d     = ack_pend_q;
    frame_start_d = (digit_q == 2'd0) && (slot_cnt_q == '0);
    if (dig_on) begin
      an_d   = ~(4'b0001 << digit_q);
      sseg_d = seg_sh_q[digit_q];
      dp_d   = ~dp_sh_q[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      slot_cnt_q    <= '0;
      digit_q       <= 2'd0;
      seg_sh_q      <= {4{7'h7F}};
      dp_sh_q       <= 4'h0;
      dig_en_sh_q   <= 4'h0;
      ack_pend_q    <= 1'b0;
      upd_ack_q     <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= 4'hF;
      sseg_q        <= 7'h7F;
      dp_q          <= 1'b1;
`ifdef SEG_PWM_EN
      pwm_cnt_q     <= 4'd0;
      bright_sh_q   <= 4'hF;
`endif
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      digit_q       <= digit_d;
      seg_sh_q      <= seg_sh_d;
      dp_sh_q       <= dp_sh_d;
      dig_en_sh_q   <= dig_en_sh_d;
      ack_pend_q    <= ack_pend_d;
      upd_ack_q     <= upd_ack_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      dp_q          <= dp_d;
`ifdef SEG_PWM_EN
      pwm_cnt_q     <= pwm_cnt_d;
      bright_sh_q   <= bright_sh_d;
`endif
    end
  end

  assign upd_ack     = upd_ack_q;
  assign frame_start = frame_start_q;
  assign an          = an_q;
  assign sseg        = sseg_q;
  assign dp          = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with TICK_DIV=40, BLANK_CYC=4.
// The reference model indexes time since reset release and derives digit,
// slot offset and PWM phase arithmetically from it.
module tb_seg_scan_ctrl;

  localparam int TD = 40;
  localparam int BC = 4;
  localparam int FR = 4 * TD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in [4];
  logic [3:0] dp_in, dig_en, bright;
  logic       upd_req;
  logic       upd_ack, frame_start, dp;
  logic [3:0] an;
  logic [6:0] sseg;

  int total = 0;
  int bad = 0;

  // reference model state
  int         k;
  logic [6:0] m_seg [4];
  logic [3:0] m_dp, m_en, m_bright;
  bit         load_prev;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg0(seg_in[0]), .seg1(seg_in[1]), .seg2(seg_in[2]), .seg3(seg_in[3]),
    .dp_in(dp_in), .dig_en(dig_en), .bright(bright), .upd_req(upd_req),
    .upd_ack(upd_ack), .frame_start(frame_start),
    .an(an), .sseg(sseg), .dp(dp)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) m_seg[i] = 7'h7F;
    m_dp      = 4'h0;
    m_en      = 4'h0;
    m_bright  = 4'hF;
    load_prev = 0;
  endfunction

  // One clock: predict at the rising edge, compare at the falling edge.
  task automatic cycle();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs, e_ack;
    int         p, d, s;
    bit         lit;
    @(posedge clk);
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_ack = 1'b0;
    if (rst_n) begin
      p = k % FR;
      k++;
      d = p / TD;
      s = p % TD;
      lit = (s >= BC) && m_en[d];
`ifdef SEG_PWM_EN
      if (((s - BC) % 16) > int'(m_bright)) lit = 0;
`endif
      if (lit) begin
        e_an[d] = 1'b0;
        e_seg   = m_seg[d];
        e_dp    = !m_dp[d];
      end
      e_fs  = (p == 0);
      e_ack = load_prev;
      load_prev = (p == FR - 1) && upd_req;
      if (load_prev) begin
        for (int i = 0; i < 4; i++) m_seg[i] = seg_in[i];
        m_dp = dp_in; m_en = dig_en; m_bright = bright;
      end
    end
    @(negedge clk);
    check_val("an", an, e_an);
    check_val("sseg", sseg, e_seg);
    check_val("dp", dp, e_dp);
    check_val("frame_start", frame_start, e_fs);
    check_val("upd_ack", upd_ack, e_ack);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_inputs(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpv, input logic [3:0] env,
                            input logic [3:0] brv);
    seg_in[0] = s0; seg_in[1] = s1; seg_in[2] = s2; seg_in[3] = s3;
    dp_in = dpv; dig_en = env; bright = brv;
  endtask

  // Raise upd_req and wait (bounded) for the ack; optionally keep the request
  // up for a second reload, which must come exactly one frame later.
  task automatic do_load(input bit keep_req);
    int n, n2;
    bit got;
    upd_req = 1'b1;
    n = 0; got = 0;
    while (!got && n < FR + 10) begin
      cycle(); n++; got = upd_ack;
    end
    check_val("ack_seen", got, 1);
    if (keep_req) begin
      n2 = 0; got = 0;
      while (!got && n2 < FR + 10) begin
        cycle(); n2++; got = upd_ack;
      end
      check_val("reack_gap", n2, FR);
    end
    upd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    upd_req = 1'b0;
    set_inputs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 4'h0, 4'h0);
    model_reset();
    rst_n = 1'b0;
    run(10);
    rst_n = 1'b1;
    run(2 * FR);

    set_inputs(7'h40, 7'h79, 7'h24, 7'h30, 4'b0100, 4'hF, 4'hF);
    do_load(0);
    run(FR);

    set_inputs(7'h40, 7'h79, 7'h24, 7'h30, 4'b0100, 4'b1010, 4'hF);
    do_load(0);
    run(FR);

    set_inputs(7'h12, 7'h02, 7'h78, 7'h00, 4'b1001, 4'hF, 4'd3);
    do_load(0);
    run(FR);

    // live inputs change without a request: display must not follow
    set_inputs(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
               7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    run(3 * FR);

    set_inputs(7'h08, 7'h03, 7'h46, 7'h21, 4'b0011, 4'hF, 4'd0);
    do_load(1);
    run(FR / 2);

    for (int it = 0; it < 6; it++) begin
      run($urandom_range(0, 200));
      set_inputs(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      do_load(($urandom_range(0, 3) == 0));
      run($urandom_range(20, 120));
    end

    set_inputs(7'h00, 7'h00, 7'h00, 7'h00, 4'hF, 4'hF, 4'hF);
    do_load(0);
    for (int i = 0; i < 2 * FR && ((k % FR) / TD) != 2; i++) cycle();
    run($urandom_range(5, 30));
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_async_an", an, 4'hF);
    check_val("rst_async_sseg", sseg, 7'h7F);
    check_val("rst_async_dp", dp, 1'b1);
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    run(2 * FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
